// File: rtl/jtag_tap_lite.sv
// jtag_tap_lite: IEEE 1149.1 TAP oversampled on clk; TCK/TMS/TDI are synchronized data, never clocks.
// Define JTAG_TAP_USER_DR_EN to enable the USER data register (IR code 2); otherwise code 2 is BYPASS.
module jtag_tap_lite #(
  parameter int unsigned IR_LEN      = 4,
  parameter logic [31:0] IDCODE_VAL  = 32'h1000_0A6D,
  parameter int unsigned USER_DR_W   = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 jtag_tck,
  input  logic                 jtag_tms,
  input  logic                 jtag_tdi,
  output logic                 jtag_tdo,
  output logic                 jtag_tdo_oe,
  input  logic [USER_DR_W-1:0] user_dr_capture_data,
  output logic [USER_DR_W-1:0] user_dr_update_data,
  output logic                 user_dr_update_pulse,
  output logic                 tap_in_reset
);

  localparam int unsigned IDW = 32;

  localparam logic [3:0] ST_TLR      = 4'd0;
  localparam logic [3:0] ST_RTI      = 4'd1;
  localparam logic [3:0] ST_SEL_DR   = 4'd2;
  localparam logic [3:0] ST_CAP_DR   = 4'd3;
  localparam logic [3:0] ST_SH_DR    = 4'd4;
  localparam logic [3:0] ST_EX1_DR   = 4'd5;
  localparam logic [3:0] ST_PAUSE_DR = 4'd6;
  localparam logic [3:0] ST_EX2_DR   = 4'd7;
  localparam logic [3:0] ST_UPD_DR   = 4'd8;
  localparam logic [3:0] ST_SEL_IR   = 4'd9;
  localparam logic [3:0] ST_CAP_IR   = 4'd10;
  localparam logic [3:0] ST_SH_IR    = 4'd11;
  localparam logic [3:0] ST_EX1_IR   = 4'd12;
  localparam logic [3:0] ST_PAUSE_IR = 4'd13;
  localparam logic [3:0] ST_EX2_IR   = 4'd14;
  localparam logic [3:0] ST_UPD_IR   = 4'd15;

  localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(1);

  logic [SYNC_STAGES-1:0] tck_sync_q, tck_sync_d;
  logic [SYNC_STAGES-1:0] tms_sync_q, tms_sync_d;
  logic [SYNC_STAGES-1:0] tdi_sync_q, tdi_sync_d;
  logic                   tck_prev_q, tck_prev_d;
  logic                   tck_s, tms_s, tdi_s, tck_rise, tck_fall;

  logic [3:0]             state_q, state_d;
  logic [IR_LEN-1:0]      ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [IDW-1:0]         id_sr_q, id_sr_d;
  logic                   byp_q, byp_d;
  logic [USER_DR_W-1:0]   user_sr_q, user_sr_d, user_upd_q, user_upd_d;
  logic                   pulse_q, pulse_d;
  logic                   tdo_q, tdo_d, oe_q, oe_d, tlr_q, tlr_d;
  logic                   sel_idcode, sel_user, dr_lsb;

  assign tck_s    = tck_sync_q[SYNC_STAGES-1];
  assign tms_s    = tms_sync_q[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync_q[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_prev_q;
  assign tck_fall = ~tck_s & tck_prev_q;

  assign sel_idcode = (ir_q == IR_IDCODE);
`ifdef JTAG_TAP_USER_DR_EN
  localparam logic [IR_LEN-1:0] IR_USER = IR_LEN'(2);
  assign sel_user = (ir_q == IR_USER);
`else
  // User DR is never selected, so its flops keep their reset value of 0 and optimize away.
  assign sel_user = 1'b0;
`endif
  assign dr_lsb = sel_idcode ? id_sr_q[0] : (sel_user ? user_sr_q[0] : byp_q);

  // Synchronizers: TMS/TDI share TCK's depth so they stay aligned with the detected edge.
  always_comb begin
    tck_sync_d = {tck_sync_q[SYNC_STAGES-2:0], jtag_tck};
    tms_sync_d = {tms_sync_q[SYNC_STAGES-2:0], jtag_tms};
    tdi_sync_d = {tdi_sync_q[SYNC_STAGES-2:0], jtag_tdi};
    tck_prev_d = tck_s;
  end

  // TAP state transitions, advancing only on a detected TCK rise.
  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      case (state_q)
        ST_TLR:      state_d = tms_s ? ST_TLR    : ST_RTI;
        ST_RTI:      state_d = tms_s ? ST_SEL_DR : ST_RTI;
        ST_SEL_DR:   state_d = tms_s ? ST_SEL_IR : ST_CAP_DR;
        ST_CAP_DR:   state_d = tms_s ? ST_EX1_DR : ST_SH_DR;
        ST_SH_DR:    state_d = tms_s ? ST_EX1_DR : ST_SH_DR;
        ST_EX1_DR:   state_d = tms_s ? ST_UPD_DR : ST_PAUSE_DR;
        ST_PAUSE_DR: state_d = tms_s ? ST_EX2_DR : ST_PAUSE_DR;
        ST_EX2_DR:   state_d = tms_s ? ST_UPD_DR : ST_SH_DR;
        ST_UPD_DR:   state_d = tms_s ? ST_SEL_DR : ST_RTI;
        ST_SEL_IR:   state_d = tms_s ? ST_TLR    : ST_CAP_IR;
        ST_CAP_IR:   state_d = tms_s ? ST_EX1_IR : ST_SH_IR;
        ST_SH_IR:    state_d = tms_s ? ST_EX1_IR : ST_SH_IR;
        ST_EX1_IR:   state_d = tms_s ? ST_UPD_IR : ST_PAUSE_IR;
        ST_PAUSE_IR: state_d = tms_s ? ST_EX2_IR : ST_PAUSE_IR;
        ST_EX2_IR:   state_d = tms_s ? ST_UPD_IR : ST_SH_IR;
        ST_UPD_IR:   state_d = tms_s ? ST_SEL_DR : ST_RTI;
        default:     state_d = ST_TLR;
      endcase
    end
    oe_d  = (state_d == ST_SH_IR) || (state_d == ST_SH_DR);
    tlr_d = (state_d == ST_TLR);
  end

  // Capture/shift on TCK rise; TDO and update actions on TCK fall.
  always_comb begin
    ir_d       = ir_q;
    ir_sr_d    = ir_sr_q;
    id_sr_d    = id_sr_q;
    byp_d      = byp_q;
    user_sr_d  = user_sr_q;
    user_upd_d = user_upd_q;
    pulse_d    = 1'b0;
    tdo_d      = tdo_q;
    if (tck_rise) begin
      case (state_q)
        ST_CAP_IR: ir_sr_d = IR_LEN'(1);
        ST_SH_IR:  ir_sr_d = IR_LEN'({tdi_s, ir_sr_q} >> 1);
        ST_CAP_DR: begin
          if (sel_idcode)    id_sr_d   = IDCODE_VAL;
          else if (sel_user) user_sr_d = user_dr_capture_data;
          else               byp_d     = 1'b0;
        end
        ST_SH_DR: begin
          if (sel_idcode)    id_sr_d   = IDW'({tdi_s, id_sr_q} >> 1);
          else if (sel_user) user_sr_d = USER_DR_W'({tdi_s, user_sr_q} >> 1);
          else               byp_d     = tdi_s;
        end
        default: ;
      endcase
    end
    if (tck_fall) begin
      tdo_d = 1'b0;
      case (state_q)
        ST_SH_IR:  tdo_d = ir_sr_q[0];
        ST_SH_DR:  tdo_d = dr_lsb;
        ST_UPD_IR: ir_d  = ir_sr_q;
        ST_UPD_DR: begin
          if (sel_user) begin
            user_upd_d = user_sr_q;
            pulse_d    = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (state_q == ST_TLR) ir_d = IR_IDCODE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tck_sync_q <= '0;
      tms_sync_q <= '0;
      tdi_sync_q <= '0;
      tck_prev_q <= 1'b0;
      state_q    <= ST_TLR;
      ir_q       <= IR_IDCODE;
      ir_sr_q    <= '0;
      id_sr_q    <= '0;
      byp_q      <= 1'b0;
      user_sr_q  <= '0;
      user_upd_q <= '0;
      pulse_q    <= 1'b0;
      tdo_q      <= 1'b0;
      oe_q       <= 1'b0;
      tlr_q      <= 1'b1;
    end else begin
      tck_sync_q <= tck_sync_d;
      tms_sync_q <= tms_sync_d;
      tdi_sync_q <= tdi_sync_d;
      tck_prev_q <= tck_prev_d;
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_sr_q    <= ir_sr_d;
      id_sr_q    <= id_sr_d;
      byp_q      <= byp_d;
      user_sr_q  <= user_sr_d;
      user_upd_q <= user_upd_d;
      pulse_q    <= pulse_d;
      tdo_q      <= tdo_d;
      oe_q       <= oe_d;
      tlr_q      <= tlr_d;
    end
  end

  assign jtag_tdo             = tdo_q;
  assign jtag_tdo_oe          = oe_q;
  assign user_dr_update_data  = user_upd_q;
  assign user_dr_update_pulse = pulse_q;
  assign tap_in_reset         = tlr_q;

endmodule

// File: tb/tb_jtag_tap_lite.sv
// tb_jtag_tap_lite: drives TCK/TMS/TDI as slow async data and checks jtag_tap_lite against a
// TCK-cycle-level model built from bit queues; honours JTAG_TAP_USER_DR_EN like the design.
module tb_jtag_tap_lite;

  localparam int unsigned IR_LEN    = 4;
  localparam int unsigned USER_DR_W = 32;
  localparam logic [31:0] IDCODE    = 32'h1000_0A6D;
  localparam int          HALF      = 6;

  logic                 clk;
  logic                 rst;
  logic                 jtag_tck, jtag_tms, jtag_tdi;
  logic                 jtag_tdo, jtag_tdo_oe;
  logic [USER_DR_W-1:0] cap_data;
  logic [USER_DR_W-1:0] user_dr_update_data;
  logic                 user_dr_update_pulse;
  logic                 tap_in_reset;

  jtag_tap_lite dut (
    .clk                  (clk),
    .rst                  (rst),
    .jtag_tck             (jtag_tck),
    .jtag_tms             (jtag_tms),
    .jtag_tdi             (jtag_tdi),
    .jtag_tdo             (jtag_tdo),
    .jtag_tdo_oe          (jtag_tdo_oe),
    .user_dr_capture_data (cap_data),
    .user_dr_update_data  (user_dr_update_data),
    .user_dr_update_pulse (user_dr_update_pulse),
    .tap_in_reset         (tap_in_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int dut_pulses = 0;
  int pw = 0;
  event chk_ev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_TLR, M_RTI, M_SDR, M_CDR, M_SHDR, M_E1DR, M_PDR, M_E2DR, M_UDR,
                    M_SIR, M_CIR, M_SHIR, M_E1IR, M_PIR, M_E2IR, M_UIR} mst_t;

  mst_t                 m_st;
  logic [IR_LEN-1:0]    m_ir;
  bit                   m_irq[$];
  bit                   m_drq[$];
  bit                   m_tdo;
  logic [USER_DR_W-1:0] m_upd;
  int                   m_pulses;

  function automatic mst_t nxt(mst_t s, bit tms);
    case (s)
      M_TLR:  return tms ? M_TLR  : M_RTI;
      M_RTI:  return tms ? M_SDR  : M_RTI;
      M_SDR:  return tms ? M_SIR  : M_CDR;
      M_CDR:  return tms ? M_E1DR : M_SHDR;
      M_SHDR: return tms ? M_E1DR : M_SHDR;
      M_E1DR: return tms ? M_UDR  : M_PDR;
      M_PDR:  return tms ? M_E2DR : M_PDR;
      M_E2DR: return tms ? M_UDR  : M_SHDR;
      M_UDR:  return tms ? M_SDR  : M_RTI;
      M_SIR:  return tms ? M_TLR  : M_CIR;
      M_CIR:  return tms ? M_E1IR : M_SHIR;
      M_SHIR: return tms ? M_E1IR : M_SHIR;
      M_E1IR: return tms ? M_UIR  : M_PIR;
      M_PIR:  return tms ? M_E2IR : M_PIR;
      M_E2IR: return tms ? M_UIR  : M_SHIR;
      M_UIR:  return tms ? M_SDR  : M_RTI;
      default: return M_TLR;
    endcase
  endfunction

  // 1 = IDCODE, 2 = USER, 0 = BYPASS
  function automatic int m_kind();
    if (m_ir == IR_LEN'(1)) return 1;
`ifdef JTAG_TAP_USER_DR_EN
    if (m_ir == IR_LEN'(2)) return 2;
`endif
    return 0;
  endfunction

  task automatic m_reset();
    m_st = M_TLR; m_ir = IR_LEN'(1); m_tdo = 1'b0; m_upd = '0;
    m_irq.delete(); m_drq.delete();
  endtask

  task automatic m_fall();
    m_tdo = 1'b0;
    if (m_st == M_SHIR) m_tdo = m_irq[0];
    if (m_st == M_SHDR) m_tdo = m_drq[0];
    if (m_st == M_UIR) for (int i = 0; i < IR_LEN; i++) m_ir[i] = m_irq[i];
    if (m_st == M_UDR && m_kind() == 2) begin
      for (int i = 0; i < USER_DR_W; i++) m_upd[i] = m_drq[i];
      m_pulses++;
    end
  endtask

  task automatic m_rise(input bit tms, input bit tdi);
    case (m_st)
      M_CIR: begin
        m_irq.delete();
        m_irq.push_back(1'b1);
        for (int i = 1; i < IR_LEN; i++) m_irq.push_back(1'b0);
      end
      M_CDR: begin
        m_drq.delete();
        if (m_kind() == 1)      for (int i = 0; i < 32; i++) m_drq.push_back(IDCODE[i]);
        else if (m_kind() == 2) for (int i = 0; i < USER_DR_W; i++) m_drq.push_back(cap_data[i]);
        else                    m_drq.push_back(1'b0);
      end
      M_SHIR: begin void'(m_irq.pop_front()); m_irq.push_back(tdi); end
      M_SHDR: begin void'(m_drq.pop_front()); m_drq.push_back(tdi); end
      default: ;
    endcase
    m_st = nxt(m_st, tms);
    if (m_st == M_TLR) m_ir = IR_LEN'(1);
  endtask

  // ---------------- compare process ----------------
  always @(chk_ev) begin
    chk("tdo", 64'(jtag_tdo), 64'(m_tdo));
    chk("tdo_oe", 64'(jtag_tdo_oe), 64'(m_st == M_SHIR || m_st == M_SHDR));
    chk("tap_in_reset", 64'(tap_in_reset), 64'(m_st == M_TLR));
    chk("upd_data", 64'(user_dr_update_data), 64'(m_upd));
  end

  // Counts pulses and checks each is exactly one clk wide.
  always @(negedge clk) begin
    if (user_dr_update_pulse === 1'b1) begin
      if (pw == 0) dut_pulses++;
      pw++;
    end else if (pw != 0) begin
      chk("pulse_width", 64'(pw), 64'd1);
      pw = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tck_cycle(input bit tms, input bit tdi, output logic obs);
    jtag_tck = 1'b0; jtag_tms = tms; jtag_tdi = tdi;
    m_fall();
    repeat (HALF) @(negedge clk);
    obs = jtag_tdo;
    -> chk_ev;
    #1;
    jtag_tck = 1'b1;
    m_rise(tms, tdi);
    repeat (HALF) @(negedge clk);
  endtask

  task automatic do_reset();
    logic o;
    rst = 1'b1; jtag_tck = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_tdo", 64'(jtag_tdo), 64'd0);
    chk("rst_oe", 64'(jtag_tdo_oe), 64'd0);
    chk("rst_upd", 64'(user_dr_update_data), 64'd0);
    chk("rst_pulse", 64'(user_dr_update_pulse), 64'd0);
    chk("rst_tlr", 64'(tap_in_reset), 64'd1);
    rst = 1'b0;
    m_reset();
    tck_cycle(1'b1, 1'b0, o);
  endtask

  task automatic goto_rti();
    logic o;
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
    logic o;
    dout = '0;
    tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], o);
      dout[i] = o;
    end
    tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
  endtask

  task automatic scan_ir(input int n, input logic [63:0] din, output logic [63:0] dout);
    logic o;
    dout = '0;
    tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], o);
      dout[i] = o;
    end
    tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
  endtask

  logic [63:0] dout, din;
  logic        o;
  int          p0, n;
  logic [IR_LEN-1:0] irv;

  initial begin
    m_pulses = 0;
    cap_data = '0; jtag_tms = 1'b0; jtag_tdi = 1'b0;
    m_reset();
    do_reset();
    goto_rti();

    // IDCODE read straight after reset
    scan_dr(32, 64'd0, dout);
    chk("idcode_read", dout[31:0], 64'(IDCODE));

    // Five TMS=1 from Shift-DR returns to reset with IDCODE selected
    tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, o);
    repeat (2) @(negedge clk);
    chk("tlr_after_5tms", 64'(tap_in_reset), 64'd1);
    tck_cycle(1'b0, 1'b0, o);
    scan_dr(32, 64'd0, dout);
    chk("idcode_after_tlr", dout[31:0], 64'(IDCODE));

    // IR capture pattern, then BYPASS
    scan_ir(IR_LEN, 64'hF, dout);
    chk("ir_capture", dout[3:0], 64'h1);
    scan_dr(9, 64'h0A5, dout);
    chk("bypass_a5", dout[8:0], 64'h14A);

    // Code 2: USER register when enabled, else BYPASS
    scan_ir(IR_LEN, 64'h2, dout);
    cap_data = 32'hDEAD_BEEF;
    p0 = dut_pulses;
`ifdef JTAG_TAP_USER_DR_EN
    scan_dr(32, 64'h1234_5678, dout);
    chk("user_capture", dout[31:0], 64'hDEAD_BEEF);
    chk("user_update", 64'(user_dr_update_data), 64'h1234_5678);
    chk("user_pulse_count", 64'(dut_pulses - p0), 64'd1);
`else
    scan_dr(9, 64'h0A5, dout);
    chk("code2_bypass", dout[8:0], 64'h14A);
    chk("code2_no_pulse", 64'(dut_pulses - p0), 64'd0);
`endif

    // Reset at bit 10 of a code-2 scan aborts it
    p0 = dut_pulses;
    tck_cycle(1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    tck_cycle(1'b0, 1'b0, o);
    for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'($urandom), o);
    do_reset();
    repeat (4) @(negedge clk);
    chk("abort_no_pulse", 64'(dut_pulses - p0), 64'd0);
    chk("abort_upd_zero", 64'(user_dr_update_data), 64'd0);
    chk("abort_tlr", 64'(tap_in_reset), 64'd1);
    goto_rti();

    // Randomized scans and TMS walks
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 3))
        0: irv = IR_LEN'(1);
        1: irv = IR_LEN'(2);
        2: irv = '1;
        default: irv = IR_LEN'($urandom);
      endcase
      scan_ir(IR_LEN, 64'(irv), dout);
      cap_data = $urandom;
      din = {$urandom, $urandom};
      n = $urandom_range(1, 40);
      scan_dr(n, din, dout);
      for (int k = 0; k < 12; k++) tck_cycle($urandom_range(0, 99) < 35, 1'($urandom), o);
      if (it % 7 == 3) do_reset();
      goto_rti();
    end

    repeat (8) @(negedge clk);
    chk("pulse_total", 64'(dut_pulses), 64'(m_pulses));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
